// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state, forward-select encodings and register helpers for pipeline_hazard_ctrl
package hazard_pkg;
  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_FAULT} mem_state_t;
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_NONE = 2'b00;
  localparam fwd_sel_t FWD_WB = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  // A writer hits a source only when it really writes and the register is not $0.
  function automatic logic reg_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && dst != REG_ZERO && dst == src;
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: datapath <-> hazard controller bundle
//   master: datapath side (drives register numbers, stage flags, dmem_ready; receives controls)
//   slave : controller side (drives forward selects, stalls, flushes, dmem_req, mem_fault, counters)
interface pipeline_hazard_ctrl_if #(parameter int STAT_W = 32);
  import hazard_pkg::*;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM;
  logic branchD, jumpD, pcsrcD, dmem_ready;
  logic dmem_req;
  fwd_sel_t forwardAE, forwardBE;
  logic forwardAD, forwardBD;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_fault;
  logic [STAT_W-1:0] stall_cycles, flush_count;
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM,
           branchD, jumpD, pcsrcD, dmem_ready,
    input  dmem_req, forwardAE, forwardBE, forwardAD, forwardBD,
           stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_fault,
           stall_cycles, flush_count
  );
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM,
           branchD, jumpD, pcsrcD, dmem_ready,
    output dmem_req, forwardAE, forwardBE, forwardAD, forwardBD,
           stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_fault,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_dmem_wait_fsm.sv
// dmem_wait_fsm: data-memory wait-state sequencer with timeout
//   in : clk, reset (sync, active-high), mem_op (load/store in MEM), dmem_ready
//   out: memstall (comb), dmem_req (comb), mem_fault (registered, sticky until reset)
module dmem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_op,
  input  logic dmem_ready,
  output logic memstall,
  output logic dmem_req,
  output logic mem_fault
);
  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
  mem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fault_q, fault_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    memstall = 1'b0;
    dmem_req = mem_op && state_q != MEM_FAULT;
    case (state_q)
      MEM_IDLE: if (dmem_req && !dmem_ready) begin
        memstall = 1'b1;
        state_d = MEM_WAIT;
        cnt_d = CW'(1);
      end
      // A ready arriving on the last allowed wait cycle still completes the access.
      MEM_WAIT: begin
        memstall = !dmem_ready;
        if (dmem_ready) begin
          state_d = MEM_IDLE;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) state_d = MEM_FAULT;
        else cnt_d = cnt_q + 1'b1;
      end
      MEM_FAULT: memstall = 1'b1;
      default: state_d = MEM_IDLE;
    endcase
    fault_d = state_d == MEM_FAULT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign mem_fault = fault_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, stall and flush control for the 5-stage MIPS pipeline
//   clk, reset (sync, active-high); hz (slave modport): stage register numbers/flags in,
//   forward selects, stallF/D/E/M, flushD/E/W, dmem_req, mem_fault, perf counters out.
//   HAZARD_STATS_EN: when defined, stall_cycles/flush_count count saturating; otherwise tied to 0.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STAT_W = 32
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave hz
);
  logic lwstall, brstall, memstall, stall_fd;
  dmem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
    .clk(clk),
    .reset(reset),
    .mem_op(hz.memtoregM | hz.memwriteM),
    .dmem_ready(hz.dmem_ready),
    .memstall(memstall),
    .dmem_req(hz.dmem_req),
    .mem_fault(hz.mem_fault)
  );
  always_comb begin
    hz.forwardAE = reg_hit(hz.regwriteM, hz.writeregM, hz.rsE) ? FWD_MEM :
                   reg_hit(hz.regwriteW, hz.writeregW, hz.rsE) ? FWD_WB : FWD_NONE;
    hz.forwardBE = reg_hit(hz.regwriteM, hz.writeregM, hz.rtE) ? FWD_MEM :
                   reg_hit(hz.regwriteW, hz.writeregW, hz.rtE) ? FWD_WB : FWD_NONE;
    hz.forwardAD = reg_hit(hz.regwriteM, hz.writeregM, hz.rsD);
    hz.forwardBD = reg_hit(hz.regwriteM, hz.writeregM, hz.rtD);
    lwstall = hz.memtoregE && (reg_hit(1'b1, hz.rtE, hz.rsD) || reg_hit(1'b1, hz.rtE, hz.rtD));
    brstall = hz.branchD && (reg_hit(hz.regwriteE, hz.writeregE, hz.rsD) ||
                             reg_hit(hz.regwriteE, hz.writeregE, hz.rtD) ||
                             reg_hit(hz.memtoregM, hz.writeregM, hz.rsD) ||
                             reg_hit(hz.memtoregM, hz.writeregM, hz.rtD));
    stall_fd = lwstall | brstall | memstall;
    hz.stallF = stall_fd;
    hz.stallD = stall_fd;
    hz.stallE = memstall;
    hz.stallM = memstall;
    // A frozen E/M must not also receive a bubble, so memstall suppresses flushE.
    hz.flushE = (lwstall | brstall) & ~memstall;
    // A stalled taken branch re-resolves once the stall clears, so no flush yet.
    hz.flushD = (hz.pcsrcD | hz.jumpD) & ~stall_fd;
    // Bubble into WB so the frozen MEM instruction is written back only once.
    hz.flushW = memstall;
  end
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] sc_q, sc_d, fc_q, fc_d;
  always_comb begin
    sc_d = sc_q + STAT_W'(hz.stallF && !(&sc_q));
    fc_d = fc_q + STAT_W'((hz.flushD | hz.flushE) && !(&fc_q));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      sc_q <= sc_d;
      fc_q <= fc_d;
    end
  end
  assign hz.stall_cycles = sc_q;
  assign hz.flush_count = fc_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks against a cycle-level behavioural model
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  int run = 0;
  bit fault = 1'b0;
  logic [31:0] sc = '0;
  logic [31:0] fc = '0;
  pipeline_hazard_ctrl_if #(.STAT_W(32)) hz ();
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .STAT_W(32)) dut (.clk(clk), .reset(reset), .hz(hz));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit hit(input bit we, input logic [4:0] d, input logic [4:0] s);
    return we && d != 5'd0 && d == s;
  endfunction
  task automatic clr();
    {hz.rsD, hz.rtD, hz.rsE, hz.rtE, hz.writeregE, hz.writeregM, hz.writeregW} = '0;
    {hz.regwriteE, hz.regwriteM, hz.regwriteW, hz.memtoregE, hz.memtoregM, hz.memwriteM} = '0;
    {hz.branchD, hz.jumpD, hz.pcsrcD} = '0;
    hz.dmem_ready = 1'b1;
  endtask
  // Check one cycle against the model, then advance the model across the clock edge.
  task automatic step();
    bit req, ms, lw, br, sf, fd, fe;
    bit [1:0] fa, fb;
    logic [31:0] esc, efc;
    req = hz.memtoregM | hz.memwriteM;
    ms = fault || (run > 0 ? !hz.dmem_ready : req && !hz.dmem_ready);
    lw = hz.memtoregE && (hit(1'b1, hz.rtE, hz.rsD) || hit(1'b1, hz.rtE, hz.rtD));
    br = hz.branchD && (hit(hz.regwriteE, hz.writeregE, hz.rsD) || hit(hz.regwriteE, hz.writeregE, hz.rtD) ||
                        hit(hz.memtoregM, hz.writeregM, hz.rsD) || hit(hz.memtoregM, hz.writeregM, hz.rtD));
    sf = lw | br | ms;
    fe = (lw | br) & !ms;
    fd = (hz.pcsrcD | hz.jumpD) & !sf;
    fa = hit(hz.regwriteM, hz.writeregM, hz.rsE) ? 2'd2 : hit(hz.regwriteW, hz.writeregW, hz.rsE) ? 2'd1 : 2'd0;
    fb = hit(hz.regwriteM, hz.writeregM, hz.rtE) ? 2'd2 : hit(hz.regwriteW, hz.writeregW, hz.rtE) ? 2'd1 : 2'd0;
`ifdef HAZARD_STATS_EN
    esc = sc;
    efc = fc;
`else
    esc = '0;
    efc = '0;
`endif
    #2;
    check("fwd", 32'({hz.forwardAE, hz.forwardBE, hz.forwardAD, hz.forwardBD}),
          32'({fa, fb, hit(hz.regwriteM, hz.writeregM, hz.rsD), hit(hz.regwriteM, hz.writeregM, hz.rtD)}));
    check("stall", 32'({hz.stallF, hz.stallD, hz.stallE, hz.stallM}), 32'({sf, sf, ms, ms}));
    check("flush", 32'({hz.flushD, hz.flushE, hz.flushW}), 32'({fd, fe, ms}));
    check("dmem_req", 32'(hz.dmem_req), 32'(req && !fault));
    check("mem_fault", 32'(hz.mem_fault), 32'(fault));
    check("stall_cycles", hz.stall_cycles, esc);
    check("flush_count", hz.flush_count, efc);
    @(posedge clk);
    if (reset) begin
      run = 0;
      fault = 1'b0;
      sc = '0;
      fc = '0;
    end else begin
      if (!fault) begin
        if (run > 0 && hz.dmem_ready) run = 0;
        else if (ms) begin
          run++;
          if (run == TO) fault = 1'b1;
        end
      end
      if (sf && sc != '1) sc++;
      if ((fd | fe) && fc != '1) fc++;
    end
    #1;
  endtask
  initial begin
    clr();
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    hz.regwriteM = 1'b1; hz.writeregM = 5'd8; hz.rsE = 5'd8;
    step();
    check("fwdAE_mem", 32'(hz.forwardAE), 32'd2);
    hz.regwriteW = 1'b1; hz.writeregW = 5'd8;
    step();
    check("fwdAE_mem_over_wb", 32'(hz.forwardAE), 32'd2);
    hz.writeregM = 5'd0; hz.rsE = 5'd0; hz.writeregW = 5'd0;
    step();
    check("fwdAE_r0", 32'(hz.forwardAE), 32'd0);
    clr();
    hz.memtoregE = 1'b1; hz.rtE = 5'd9; hz.rsD = 5'd9;
    step();
    clr();
    hz.regwriteM = 1'b1; hz.memtoregM = 1'b1; hz.writeregM = 5'd9; hz.rsE = 5'd9;
    step();
    clr();
    hz.branchD = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd4; hz.rsD = 5'd4;
    step();
    clr();
    hz.branchD = 1'b1; hz.pcsrcD = 1'b1;
    step();
    check("branch_flushD", 32'(hz.flushD), 32'd1);
    clr();
    hz.memtoregM = 1'b1; hz.dmem_ready = 1'b0;
    repeat (3) step();
    hz.dmem_ready = 1'b1;
    step();
    clr();
    hz.memtoregM = 1'b1; hz.dmem_ready = 1'b0; hz.memtoregE = 1'b1; hz.rtE = 5'd3; hz.rsD = 5'd3; hz.pcsrcD = 1'b1;
    repeat (TO + 2) step();
    check("fault_sticky", 32'(hz.mem_fault), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clr();
    step();
    check("fault_cleared", 32'(hz.mem_fault), 32'd0);
    hz.memtoregM = 1'b1; hz.dmem_ready = 1'b0;
    repeat (TO - 1) step();
    hz.dmem_ready = 1'b1;
    step();
    clr();
    step();
    for (int i = 0; i < 3000; i++) begin
      hz.rsD = 5'($urandom_range(0, 3)); hz.rtD = 5'($urandom_range(0, 3));
      hz.rsE = 5'($urandom_range(0, 3)); hz.rtE = 5'($urandom_range(0, 3));
      hz.writeregE = 5'($urandom_range(0, 3)); hz.writeregM = 5'($urandom_range(0, 3));
      hz.writeregW = 5'($urandom_range(0, 3));
      hz.regwriteE = 1'($urandom_range(0, 1)); hz.regwriteM = 1'($urandom_range(0, 1));
      hz.regwriteW = 1'($urandom_range(0, 1)); hz.memtoregE = 1'($urandom_range(0, 1));
      hz.memtoregM = $urandom_range(0, 3) == 0; hz.memwriteM = $urandom_range(0, 3) == 0;
      hz.branchD = 1'($urandom_range(0, 1)); hz.jumpD = $urandom_range(0, 5) == 0;
      hz.pcsrcD = 1'($urandom_range(0, 1)); hz.dmem_ready = $urandom_range(0, 2) != 0;
      reset = $urandom_range(0, 40) == 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage MIPS pipeline. It sequences the F/D, D/E, E/M and M/W pipeline registers through stall, flush and forward controls. It detects load-use and branch-operand hazards and runs a data-memory wait-state FSM with timeout. It sits beside the datapath and drives the enables and clears of every pipeline register, including the MEM/WB register.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum WAIT cycles before a memory fault is raised (≥2)
- STAT_W, 32: width of the performance counters

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- rsD, rtD  in  5 each  source register numbers in Decode
- rsE, rtE  in  5 each  source register numbers in Execute
- writeregE, writeregM, writeregW  in  5 each  destination register per stage
- regwriteE, regwriteM, regwriteW  in  1 each  register-write enable per stage
- memtoregE, memtoregM  in  1 each  load in stage
- memwriteM  in  1  store in Memory
- branchD, jumpD  in  1 each  branch/jump in Decode
- pcsrcD  in  1  branch resolved taken in Decode
- dmem_ready  in  1  data memory completes access this cycle
- dmem_req  out  1  data-memory access request
- forwardAE, forwardBE  out  2 each  Execute operand mux select
- forwardAD, forwardBD  out  1 each  Decode comparator forward from MEM
- stallF, stallD, stallE, stallM  out  1 each  hold register (enable low)
- flushD, flushE, flushW  out  1 each  clear register to bubble on next edge
- mem_fault  out  1  sticky timeout flag
- stall_cycles, flush_count  out  STAT_W each  performance counters

## Operation
- Register $0 never matches for forwarding or hazards.
- forwardAE: FWD_MEM (2'b10) if regwriteM && writeregM==rsE; else FWD_WB (2'b01) if regwriteW && writeregW==rsE; else FWD_NONE. Same rule for forwardBE using rtE. MEM wins over WB.
- forwardAD/BD: regwriteM && writeregM==rsD/rtD.
- lwstall = memtoregE && (rtE==rsD || rtE==rtD).
- brstall = branchD && ((regwriteE && writeregE∈{rsD,rtD}) || (memtoregM && writeregM∈{rsD,rtD})).
- memstall is defined in the memory FSM below.
- stallF = stallD = lwstall | brstall | memstall.
- stallE = stallM = memstall.
- flushE = (lwstall | brstall) & ~memstall.
- flushD = (pcsrcD | jumpD) & ~stallD.
- flushW = memstall: a bubble enters WB so a frozen MEM instruction is written back exactly once.
- Memory FSM, states MEM_IDLE, MEM_WAIT, MEM_FAULT:
  - dmem_req = (memtoregM | memwriteM) & state≠MEM_FAULT.
  - MEM_IDLE: if request and dmem_ready, the access takes zero waits and there is no stall. If request and !dmem_ready, memstall=1, go to MEM_WAIT, wait_cnt←1.
  - MEM_WAIT: memstall = !dmem_ready. If ready, go to MEM_IDLE and clear wait_cnt. Else if wait_cnt==MEM_TIMEOUT-1, go to MEM_FAULT. Else wait_cnt++.
  - MEM_FAULT: memstall=1 and mem_fault=1 permanently; only reset leaves this state.
- wait_cnt width is $clog2(MEM_TIMEOUT).

## Timing
- Every output except mem_fault and the counters is combinational from the inputs and current state: zero-cycle latency.
- mem_fault is asserted in the first cycle of MEM_FAULT, which is MEM_TIMEOUT cycles after the stall began.
- Reset (any state, including mid-WAIT): next cycle state=MEM_IDLE, wait_cnt=0, mem_fault=0, counters=0. Combinational outputs then follow the inputs.
- Simultaneous lwstall and memstall: memstall dominates, E and M are held, and flushE=0.
- Simultaneous taken branch and stallD: flushD=0 and the branch re-resolves after the stall.
- dmem_ready that arrives in the same cycle the WAIT count reaches its limit wins: the FSM returns to MEM_IDLE, not MEM_FAULT.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_cycles increments every cycle stallF=1.
  - flush_count increments every cycle flushD|flushE=1.
  - Both counters saturate at all-ones and clear on reset.
- HAZARD_STATS_EN undefined: the counter logic is omitted; the ports remain and are tied to 0.

## Structure
- hazard_pkg holds:
  - typedef enum logic [1:0] mem_state_t {MEM_IDLE, MEM_WAIT, MEM_FAULT}
  - typedef logic [1:0] fwd_sel_t with constants FWD_NONE, FWD_WB, FWD_MEM
  - localparam REG_ZERO = 5'd0
- One sub-module, dmem_wait_fsm, owns the memory FSM, wait_cnt and mem_fault. It exports memstall and dmem_req.
- Forwarding and hazard detection stay in the top module.

## Test plan
- Forwarding: regwriteM=1, writeregM=8, rsE=8 → forwardAE=2'b10; same plus regwriteW=1, writeregW=8 → still 2'b10; rsE=0 with writeregM=0 → 2'b00.
- Load-use: memtoregE=1, rtE=9, rsD=9 → stallF=stallD=1, flushE=1, stallE=0 for one cycle; the next cycle forwards from MEM.
- Branch: branchD=1, regwriteE=1, writeregE=rsD=4 → brstall=1. Next cycle, pcsrcD=1 with no hazard → flushD=1.
- Memory wait: memtoregM=1, dmem_ready low for 3 cycles → all stalls and flushW=1 for 3 cycles. Cycle 4 with ready → no stall, state MEM_IDLE.
- Timeout/reset: MEM_TIMEOUT=4 with ready held low → mem_fault=1 after 4 stall cycles and stays 1. Pulsing reset for one cycle → mem_fault=0 and MEM_IDLE; with HAZARD_STATS_EN, stall_cycles=0.
